// File: rtl/dmem_responder_if.sv
// Request/response bundle between an LSQ dmem port (master) and a memory responder (slave).
// Requests are level signals held by the master until the cycle the slave pulses dmem_resp.
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem_raddr;
  logic        dmem_resp;
  logic        dmem_err;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_raddr, dmem_resp, dmem_err
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_raddr, dmem_resp, dmem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-masked backing-store responder: one request at a time, resp pulses LATENCY edges after acceptance.
// No ready signal: requests are ignored outside IDLE, so the initiator holds them until it sees dmem_resp.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h1eceb000
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   dmem,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  rmask_q;
  logic [3:0]  wmask_q;
  logic [3:0]  cnt;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] raddr_q;
  logic        resp;
  logic [31:0] mem [DEPTH_WORDS];

  logic        req;
  logic        access;
  logic        bad;
  logic [29:0] word_off;
  logic [AW-1:0] idx;
  logic [31:0] load_data;

  assign req    = (dmem.dmem_rmask != 4'h0) || (dmem.dmem_wmask != 4'h0);
  assign access = (state == WAIT) && (cnt == 4'd0);

  // Explicit addr<BASE check keeps the unsigned subtraction from aliasing low addresses into range.
  assign word_off = addr_q[31:2] - BASE_ADDR[31:2];
  assign idx      = word_off[AW-1:0];
  assign bad      = (addr_q[1:0] != 2'b00)
                 || (addr_q < BASE_ADDR)
                 || (word_off >= 30'(DEPTH_WORDS))
                 || ((rmask_q != 4'h0) && (wmask_q != 4'h0));

  always_comb begin
    load_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (rmask_q[i]) load_data[8*i +: 8] = mem[idx][8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    resp      = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        resp      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && req) begin
      addr_q  <= dmem.dmem_addr;
      rmask_q <= dmem.dmem_rmask;
      wmask_q <= dmem.dmem_wmask;
      wdata_q <= dmem.dmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      if (state == IDLE && req)       cnt <= 4'(LATENCY - 1);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (access) begin
        raddr_q <= addr_q;
        err_q   <= bad;
        rdata_q <= bad ? 32'h0 : load_data;
      end
    end
  end

  // Array is deliberately outside reset so contents survive rst; rst on the access edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && access && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dmem.dmem_resp  = resp;
  assign dmem.dmem_err   = resp & err_q;
  assign dmem.dmem_rdata = rdata_q;
  assign dmem.dmem_raddr = raddr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=3 and a LATENCY=1 instance share one stimulus bus,
// checked every cycle against a timeline/shadow-memory model plus literal expectations.
module tb_dmem_responder;
  localparam logic [31:0] BASE  = 32'h1eceb000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] t_addr  = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_rm    = '0;
  logic [3:0]  t_wm    = '0;
  bit          t_sel   = 1'b0;

  dmem_responder_if bus3();
  dmem_responder_if bus1();
  logic busy3, busy1;

  assign bus3.dmem_addr  = t_addr;
  assign bus3.dmem_wdata = t_wdata;
  assign bus3.dmem_rmask = t_sel ? 4'h0 : t_rm;
  assign bus3.dmem_wmask = t_sel ? 4'h0 : t_wm;
  assign bus1.dmem_addr  = t_addr;
  assign bus1.dmem_wdata = t_wdata;
  assign bus1.dmem_rmask = t_sel ? t_rm : 4'h0;
  assign bus1.dmem_wmask = t_sel ? t_wm : 4'h0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_dut3 (
    .clk(clk), .rst(rst), .dmem(bus3), .busy(busy3));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst(rst), .dmem(bus1), .busy(busy1));

  logic        o_resp [2];
  logic        o_err  [2];
  logic        o_busy [2];
  logic [31:0] o_rdata[2];
  logic [31:0] o_raddr[2];
  logic [3:0]  i_rm   [2];
  logic [3:0]  i_wm   [2];
  assign o_resp[0] = bus3.dmem_resp;  assign o_resp[1] = bus1.dmem_resp;
  assign o_err[0]  = bus3.dmem_err;   assign o_err[1]  = bus1.dmem_err;
  assign o_busy[0] = busy3;           assign o_busy[1] = busy1;
  assign o_rdata[0] = bus3.dmem_rdata; assign o_rdata[1] = bus1.dmem_rdata;
  assign o_raddr[0] = bus3.dmem_raddr; assign o_raddr[1] = bus1.dmem_raddr;
  assign i_rm[0] = bus3.dmem_rmask;   assign i_rm[1] = bus1.dmem_rmask;
  assign i_wm[0] = bus3.dmem_wmask;   assign i_wm[1] = bus1.dmem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is either free or owns one request accepted at edge acc;
  // the access happens at edge acc+lat, resp is visible until edge acc+lat+1.
  int          cyc = 0;
  int          lat [2] = '{3, 1};
  bit          pend[2] = '{1'b0, 1'b0};
  int          acc [2];
  logic [31:0] q_addr[2], q_wd[2];
  logic [3:0]  q_rm[2], q_wm[2];
  logic [31:0] e_rdata[2], e_raddr[2];
  bit          e_err[2];
  bit [31:0]   shadow[int];
  int          last_resp[2] = '{-100, -100};

  task automatic model_access(input int i);
    logic [31:0] a;
    logic [31:0] word;
    int          key;
    bit          err;
    a   = q_addr[i];
    err = (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) >> 2) >= DEPTH)
       || (q_rm[i] != 4'h0 && q_wm[i] != 4'h0);
    e_err[i]   = err;
    e_raddr[i] = a;
    e_rdata[i] = '0;
    if (!err) begin
      key  = i * DEPTH + int'((a - BASE) >> 2);
      word = shadow.exists(key) ? shadow[key] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (q_wm[i][b]) word[8*b +: 8] = q_wd[i][8*b +: 8];
        if (q_rm[i][b]) e_rdata[i][8*b +: 8] = word[8*b +: 8];
      end
      shadow[key] = word;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) pend[i] = 1'b0;
      else if (pend[i]) begin
        if (cyc == acc[i] + lat[i])          model_access(i);
        else if (cyc == acc[i] + lat[i] + 1) pend[i] = 1'b0;
      end else if ((i_rm[i] | i_wm[i]) != 4'h0) begin
        pend[i]   = 1'b1;
        acc[i]    = cyc;
        q_addr[i] = t_addr;
        q_wd[i]   = t_wdata;
        q_rm[i]   = i_rm[i];
        q_wm[i]   = i_wm[i];
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        bit er;
        er = pend[i] && (cyc == acc[i] + lat[i]);
        chk($sformatf("resp%0d", i), o_resp[i], er);
        chk($sformatf("busy%0d", i), o_busy[i], pend[i]);
        if (er) begin
          chk($sformatf("err%0d", i),   o_err[i],   e_err[i]);
          chk($sformatf("rdata%0d", i), o_rdata[i], e_rdata[i]);
          chk($sformatf("raddr%0d", i), o_raddr[i], e_raddr[i]);
        end
        if (o_resp[i]) begin
          chk($sformatf("resp_gap_ge2_%0d", i), (cyc - last_resp[i]) >= 2, 1);
          last_resp[i] = cyc;
        end
      end
    end
  end

  task automatic wait_resp(input bit s, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_resp[s]) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    chk("resp_seen", got, 1);
  endtask

  // Called at posedge+2; presents the request, waits for resp, drops it the next cycle.
  task automatic transact(input bit s, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] ra,
                          output logic e);
    int t0, t;
    t_sel = s; t_addr = a; t_rm = rm; t_wm = wm; t_wdata = wd;
    t0 = cyc;
    wait_resp(s, t);
    rd = o_rdata[s];
    ra = o_raddr[s];
    e  = o_err[s];
    if (t >= 0) chk("latency", t - t0, lat[s] + 1);
    @(posedge clk); #2;
    t_rm = 4'h0; t_wm = 4'h0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, ra;
    logic        e;
    int          r1, r2;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_rdata3", o_rdata[0], 32'h0);
    chk("rst_raddr3", o_raddr[0], 32'h0);
    chk("rst_rdata1", o_rdata[1], 32'h0);
    chk("rst_raddr1", o_raddr[1], 32'h0);
    chk("rst_err3",   o_err[0],   0);
    rst = 1'b0;

    // Full store, then load back at the same address.
    transact(0, BASE, 4'h0, 4'hf, 32'h01020304, rd, ra, e);
    transact(0, BASE + 8, 4'h0, 4'hf, 32'hdeadbeef, rd, ra, e);
    chk("t1_st_err", e, 0);
    chk("t1_st_rdata", rd, 32'h0);
    transact(0, BASE + 8, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t1_ld_rdata", rd, 32'hdeadbeef);
    chk("t1_ld_raddr", ra, BASE + 8);
    chk("t1_ld_err", e, 0);

    // Partial store into one lane, masked load of two lanes.
    transact(0, BASE + 12, 4'h0, 4'hf, 32'h11223344, rd, ra, e);
    transact(0, BASE + 12, 4'h0, 4'b0010, 32'h0000aa00, rd, ra, e);
    transact(0, BASE + 12, 4'b0110, 4'h0, 32'h0, rd, ra, e);
    chk("t2_rdata", rd, 32'h0022aa00);

    // Request held through RESP: re-accepted in the following IDLE cycle only.
    t_sel = 0; t_addr = BASE + 16; t_rm = 4'h0; t_wm = 4'hf; t_wdata = 32'h55aa55aa;
    wait_resp(0, r1);
    wait_resp(0, r2);
    chk("t3_resp_gap", r2 - r1, 5);
    @(posedge clk); #2;
    t_wm = 4'h0;
    transact(0, BASE + 16, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t3_rdata", rd, 32'h55aa55aa);

    // Error cases never touch the array.
    transact(0, BASE + 2, 4'h0, 4'hf, 32'hffffffff, rd, ra, e);
    chk("t4_mis_err", e, 1);
    chk("t4_mis_rdata", rd, 32'h0);
    chk("t4_mis_raddr", ra, BASE + 2);
    transact(0, BASE, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t4_w0_after_mis", rd, 32'h01020304);
    transact(0, BASE + 4 * DEPTH, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t4_oor_err", e, 1);
    transact(0, BASE - 4, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t4_below_err", e, 1);
    transact(0, BASE, 4'hf, 4'hf, 32'hffffffff, rd, ra, e);
    chk("t4_both_err", e, 1);
    chk("t4_both_rdata", rd, 32'h0);
    transact(0, BASE, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t4_w0_after_both", rd, 32'h01020304);
    chk("t4_w0_err", e, 0);

    // rst sampled on the access edge aborts the store and suppresses resp.
    t_sel = 0; t_addr = BASE + 8; t_rm = 4'h0; t_wm = 4'hf; t_wdata = 32'h0;
    r1 = cyc;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1; t_wm = 4'h0;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("t5_no_resp", last_resp[0] < r1, 1);
    transact(0, BASE + 8, 4'hf, 4'h0, 32'h0, rd, ra, e);
    chk("t5_word_kept", rd, 32'hdeadbeef);

    // LATENCY=1 instance: initialise 16 words, then a random mix checked by the model.
    for (int w = 0; w < 16; w++)
      transact(1, BASE + 4 * w, 4'h0, 4'hf, $urandom, rd, ra, e);
    for (int n = 0; n < 1000; n++) begin
      int          r, w;
      logic [31:0] a;
      logic [3:0]  rm, wm;
      r  = $urandom_range(0, 19);
      w  = $urandom_range(0, 15);
      a  = BASE + 4 * w;
      rm = 4'h0;
      wm = 4'h0;
      if (r < 9)       rm = 4'($urandom_range(1, 15));
      else if (r < 18) wm = 4'($urandom_range(1, 15));
      else begin
        rm = 4'hf;
        case (w % 4)
          0: a = a + 32'($urandom_range(1, 3));
          1: a = BASE + 4 * DEPTH + 4 * w;
          2: a = BASE - 4 * (w + 1);
          default: wm = 4'hf;
        endcase
      end
      transact(1, a, rm, wm, $urandom, rd, ra, e);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
